// File: rtl/fetch_unit_pkg.sv
// fetch_pkg
// Shared constants and types for the WISC instruction-fetch stage.
//   fetch_state_e : fetch FSM state encoding (3 bits)
//   NOP_INSTR     : bubble instruction placed into IF/ID
//   HALT_OPC      : opcode field value of the HALT instruction
//   PC_STEP       : byte distance between consecutive instructions
//   alignPc       : forces a target address onto a halfword boundary
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_WAIT    = 3'd1,
    ST_SQUASH  = 3'd2,
    ST_PRESENT = 3'd3,
    ST_HALT    = 3'd4
  } fetch_state_e;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]  HALT_OPC  = 5'b00000;
  localparam logic [15:0] PC_STEP   = 16'd2;

  // Instructions are 16-bit, so bit 0 of any fetch address must be zero.
  function automatic logic [15:0] alignPc(input logic [15:0] addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if
// Bundles the IF/ID handshake and the instruction-memory read port.
//   master : the fetch stage (drives memory request and IF/ID outputs)
//   slave  : the environment (hazard unit, decode, instruction memory)
// Signals:
//   Stall, Redirect, Redirect_PC      : control from hazard unit / decode
//   IMemData, IMemDone, IMemStall     : instruction memory response
//   IMemAddr, IMemRd                  : instruction memory request
//   instruct, PCInc, InstValid        : IF/ID payload
//   Halted, err                       : status
interface fetch_unit_if;
  logic        Stall;
  logic        Redirect;
  logic [15:0] Redirect_PC;
  logic [15:0] IMemData;
  logic        IMemDone;
  logic        IMemStall;
  logic [15:0] IMemAddr;
  logic        IMemRd;
  logic [15:0] instruct;
  logic [15:0] PCInc;
  logic        InstValid;
  logic        Halted;
  logic        err;

  modport master (
    input  Stall, Redirect, Redirect_PC, IMemData, IMemDone, IMemStall,
    output IMemAddr, IMemRd, instruct, PCInc, InstValid, Halted, err
  );

  modport slave (
    output Stall, Redirect, Redirect_PC, IMemData, IMemDone, IMemStall,
    input  IMemAddr, IMemRd, instruct, PCInc, InstValid, Halted, err
  );
endinterface

// File: rtl/rca_16b.sv
// rca_16b
// 16-bit ripple-carry adder.
//   A, B  : operands
//   C_in  : carry in
//   S     : sum
//   C_out : carry out of bit 15
module rca_16b (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        C_in,
  output logic [15:0] S,
  output logic        C_out
);

  logic carry;

  // Carry ripples from bit 0 upward through a chain of full adders.
  always_comb begin
    carry = C_in;
    S     = '0;
    for (int i = 0; i < 16; i++) begin
      S[i]  = A[i] ^ B[i] ^ carry;
      carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
    end
    C_out = carry;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage of the pipelined WISC core. Owns the PC, issues
// reads to the multi-cycle instruction memory and presents each fetched
// instruction with its PC+2 to decode. Accepts redirects from decode.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : fetch_unit_if.master (memory request/response, IF/ID, status)
module fetch_unit
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  instr_q, instr_d;
  logic [15:0]  pcInc_q, pcInc_d;
  logic         halted_q, halted_d;
  logic         err_q, err_d;

  logic [15:0]  pcPlus2;
  logic [15:0]  redirTarget;
  logic         unusedPcCarry;

  rca_16b pcAdder (
    .A     (pc_q),
    .B     (PC_STEP),
    .C_in  (1'b0),
    .S     (pcPlus2),
    .C_out (unusedPcCarry)
  );

  assign redirTarget = alignPc(bus.Redirect_PC);

  // A redirect in the same cycle cancels the request and hides a wrong-path
  // instruction, so these decode from state and Redirect directly.
  assign bus.IMemAddr  = pc_q;
  assign bus.IMemRd    = (state_q == ST_FETCH)   && !bus.Redirect;
  assign bus.InstValid = (state_q == ST_PRESENT) && !bus.Redirect;

  assign bus.instruct = instr_q;
  assign bus.PCInc    = pcInc_q;
  assign bus.Halted   = halted_q;
  assign bus.err      = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= '0;
      instr_q  <= NOP_INSTR;
      pcInc_q  <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pcInc_q  <= pcInc_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pcInc_d  = pcInc_q;
    halted_d = halted_q;
    err_d    = err_q;

    // Odd redirect targets are flagged but still followed (bit 0 dropped).
    // Once halted, redirects are ignored entirely.
    if (state_q != ST_HALT && bus.Redirect && bus.Redirect_PC[0]) begin
      err_d = 1'b1;
    end
    // Memory must only respond while a read is outstanding.
    if (bus.IMemDone && (state_q == ST_FETCH || state_q == ST_PRESENT ||
                         state_q == ST_HALT)) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_FETCH: begin
        if (bus.Redirect) begin
          pc_d = redirTarget;
        end else if (!bus.IMemStall) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A redirect makes the outstanding read wrong-path; if it has not
        // returned yet, SQUASH absorbs the late response.
        if (bus.Redirect) begin
          pc_d    = redirTarget;
          state_d = bus.IMemDone ? ST_FETCH : ST_SQUASH;
        end else if (bus.IMemDone) begin
          instr_d = bus.IMemData;
          pcInc_d = pcPlus2;
          pc_d    = pcPlus2;
          state_d = ST_PRESENT;
        end
      end
      ST_SQUASH: begin
        if (bus.Redirect) begin
          pc_d = redirTarget;
        end
        if (bus.IMemDone) begin
          state_d = ST_FETCH;
        end
      end
      ST_PRESENT: begin
        // The PC already points past this instruction, so a consumed
        // instruction simply returns to FETCH.
        if (bus.Redirect) begin
          instr_d = NOP_INSTR;
          pc_d    = redirTarget;
          state_d = ST_FETCH;
        end else if (!bus.Stall) begin
          if (instr_q[15:11] == HALT_OPC) begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end else begin
            instr_d = NOP_INSTR;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed self-checking bench for fetch_unit. Each scenario task drives the
// interface cycle by cycle and compares outputs against hand-derived values.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled just after the rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.Stall       = 1'b0;
    bus.Redirect    = 1'b0;
    bus.Redirect_PC = 16'h0000;
    bus.IMemData    = 16'h0000;
    bus.IMemDone    = 1'b0;
    bus.IMemStall   = 1'b0;
  endtask

  // Leaves the DUT in cycle 0 after reset (FETCH, PC=0).
  task automatic doReset();
    idleInputs();
    rst = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b0;
    #1;
  endtask

  // From FETCH with an accepted request: memory answers one cycle later.
  // Returns positioned in the PRESENT cycle.
  task automatic fetchWord(input logic [15:0] data);
    nextCycle();
    bus.IMemDone = 1'b1;
    bus.IMemData = data;
    nextCycle();
    bus.IMemDone = 1'b0;
    bus.IMemData = 16'h0000;
    #1;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (bus.instruct !== 16'h0800) begin errors++; $display("[TB] FAIL reset_instruct: got %h expected %h", bus.instruct, 16'h0800); end
    checks++; if (bus.PCInc !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pcinc: got %h expected %h", bus.PCInc, 16'h0000); end
    checks++; if (bus.InstValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.InstValid); end
    checks++; if (bus.Halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %b expected 0", bus.Halted); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.err); end
    checks++; if (bus.IMemAddr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_addr: got %h expected %h", bus.IMemAddr, 16'h0000); end
    checks++; if (bus.IMemRd !== 1'b1) begin errors++; $display("[TB] FAIL reset_rd: got %b expected 1", bus.IMemRd); end
  endtask

  task automatic test_basic_fetch();
    nextCycle();
    bus.IMemDone = 1'b1;
    bus.IMemData = 16'h4A21;
    #1;
    checks++; if (bus.IMemRd !== 1'b0) begin errors++; $display("[TB] FAIL basic_wait_rd: got %b expected 0", bus.IMemRd); end
    checks++; if (bus.InstValid !== 1'b0) begin errors++; $display("[TB] FAIL basic_wait_valid: got %b expected 0", bus.InstValid); end
    nextCycle();
    bus.IMemDone = 1'b0;
    #1;
    checks++; if (bus.InstValid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b expected 1", bus.InstValid); end
    checks++; if (bus.instruct !== 16'h4A21) begin errors++; $display("[TB] FAIL basic_instruct: got %h expected %h", bus.instruct, 16'h4A21); end
    checks++; if (bus.PCInc !== 16'h0002) begin errors++; $display("[TB] FAIL basic_pcinc: got %h expected %h", bus.PCInc, 16'h0002); end
    nextCycle();
    checks++; if (bus.IMemAddr !== 16'h0002) begin errors++; $display("[TB] FAIL basic_next_addr: got %h expected %h", bus.IMemAddr, 16'h0002); end
    checks++; if (bus.IMemRd !== 1'b1) begin errors++; $display("[TB] FAIL basic_next_rd: got %b expected 1", bus.IMemRd); end
    checks++; if (bus.instruct !== 16'h0800) begin errors++; $display("[TB] FAIL basic_nop: got %h expected %h", bus.instruct, 16'h0800); end
  endtask

  task automatic test_stall();
    fetchWord(16'h1234);
    bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.instruct !== 16'h1234) begin errors++; $display("[TB] FAIL stall_instruct[%0d]: got %h expected %h", i, bus.instruct, 16'h1234); end
      checks++; if (bus.PCInc !== 16'h0004) begin errors++; $display("[TB] FAIL stall_pcinc[%0d]: got %h expected %h", i, bus.PCInc, 16'h0004); end
      checks++; if (bus.IMemRd !== 1'b0) begin errors++; $display("[TB] FAIL stall_rd[%0d]: got %b expected 0", i, bus.IMemRd); end
      checks++; if (bus.InstValid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid[%0d]: got %b expected 1", i, bus.InstValid); end
      nextCycle();
    end
    bus.Stall = 1'b0;
    #1;
    checks++; if (bus.InstValid !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_valid: got %b expected 1", bus.InstValid); end
    nextCycle();
    checks++; if (bus.IMemAddr !== 16'h0004) begin errors++; $display("[TB] FAIL stall_next_addr: got %h expected %h", bus.IMemAddr, 16'h0004); end
    checks++; if (bus.IMemRd !== 1'b1) begin errors++; $display("[TB] FAIL stall_next_rd: got %b expected 1", bus.IMemRd); end
  endtask

  task automatic test_redirect_wait();
    nextCycle();
    bus.Redirect    = 1'b1;
    bus.Redirect_PC = 16'h0100;
    #1;
    checks++; if (bus.IMemRd !== 1'b0) begin errors++; $display("[TB] FAIL rwait_rd: got %b expected 0", bus.IMemRd); end
    nextCycle();
    bus.Redirect = 1'b0;
    #1;
    checks++; if (bus.IMemRd !== 1'b0) begin errors++; $display("[TB] FAIL rwait_squash_rd: got %b expected 0", bus.IMemRd); end
    nextCycle();
    bus.IMemDone = 1'b1;
    bus.IMemData = 16'hDEAD;
    #1;
    checks++; if (bus.InstValid !== 1'b0) begin errors++; $display("[TB] FAIL rwait_done_valid: got %b expected 0", bus.InstValid); end
    nextCycle();
    bus.IMemDone = 1'b0;
    bus.IMemData = 16'h0000;
    #1;
    checks++; if (bus.IMemAddr !== 16'h0100) begin errors++; $display("[TB] FAIL rwait_addr: got %h expected %h", bus.IMemAddr, 16'h0100); end
    checks++; if (bus.IMemRd !== 1'b1) begin errors++; $display("[TB] FAIL rwait_next_rd: got %b expected 1", bus.IMemRd); end
    checks++; if (bus.InstValid !== 1'b0) begin errors++; $display("[TB] FAIL rwait_valid: got %b expected 0", bus.InstValid); end
    checks++; if (bus.instruct !== 16'h0800) begin errors++; $display("[TB] FAIL rwait_instruct: got %h expected %h", bus.instruct, 16'h0800); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL rwait_err: got %b expected 0", bus.err); end
    fetchWord(16'h5555);
    checks++; if (bus.instruct !== 16'h5555) begin errors++; $display("[TB] FAIL rwait_target_instr: got %h expected %h", bus.instruct, 16'h5555); end
    checks++; if (bus.PCInc !== 16'h0102) begin errors++; $display("[TB] FAIL rwait_target_pcinc: got %h expected %h", bus.PCInc, 16'h0102); end
  endtask

  task automatic test_redirect_stall();
    bus.Redirect    = 1'b1;
    bus.Redirect_PC = 16'h0200;
    bus.Stall       = 1'b1;
    #1;
    checks++; if (bus.InstValid !== 1'b0) begin errors++; $display("[TB] FAIL rstall_valid: got %b expected 0", bus.InstValid); end
    nextCycle();
    idleInputs();
    #1;
    checks++; if (bus.IMemAddr !== 16'h0200) begin errors++; $display("[TB] FAIL rstall_addr: got %h expected %h", bus.IMemAddr, 16'h0200); end
    checks++; if (bus.IMemRd !== 1'b1) begin errors++; $display("[TB] FAIL rstall_rd: got %b expected 1", bus.IMemRd); end
    checks++; if (bus.instruct !== 16'h0800) begin errors++; $display("[TB] FAIL rstall_instruct: got %h expected %h", bus.instruct, 16'h0800); end
  endtask

  task automatic test_mem_stall();
    bus.IMemStall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus.IMemRd !== 1'b1 || bus.IMemAddr !== 16'h0200) begin errors++; $display("[TB] FAIL memstall_req[%0d]: got rd=%b addr=%h expected rd=1 addr=0200", i, bus.IMemRd, bus.IMemAddr); end
      nextCycle();
    end
    bus.IMemStall = 1'b0;
    #1;
    fetchWord(16'h6001);
    checks++; if (bus.InstValid !== 1'b1) begin errors++; $display("[TB] FAIL memstall_valid: got %b expected 1", bus.InstValid); end
    checks++; if (bus.PCInc !== 16'h0202) begin errors++; $display("[TB] FAIL memstall_pcinc: got %h expected %h", bus.PCInc, 16'h0202); end
    nextCycle();
    checks++; if (bus.IMemAddr !== 16'h0202) begin errors++; $display("[TB] FAIL memstall_next_addr: got %h expected %h", bus.IMemAddr, 16'h0202); end
  endtask

  task automatic test_halt_wrap();
    bus.Redirect    = 1'b1;
    bus.Redirect_PC = 16'hFFFE;
    #1;
    checks++; if (bus.IMemRd !== 1'b0) begin errors++; $display("[TB] FAIL halt_redir_rd: got %b expected 0", bus.IMemRd); end
    nextCycle();
    idleInputs();
    #1;
    checks++; if (bus.IMemAddr !== 16'hFFFE) begin errors++; $display("[TB] FAIL halt_addr: got %h expected %h", bus.IMemAddr, 16'hFFFE); end
    fetchWord(16'h0000);
    checks++; if (bus.PCInc !== 16'h0000) begin errors++; $display("[TB] FAIL halt_wrap_pcinc: got %h expected %h", bus.PCInc, 16'h0000); end
    checks++; if (bus.InstValid !== 1'b1) begin errors++; $display("[TB] FAIL halt_present_valid: got %b expected 1", bus.InstValid); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL halt_wrap_err: got %b expected 0", bus.err); end
    nextCycle();
    for (int i = 0; i < 10; i++) begin
      bus.Redirect    = i[0];
      bus.Redirect_PC = 16'h0040;
      #1;
      checks++; if (bus.Halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_halted[%0d]: got %b expected 1", i, bus.Halted); end
      checks++; if (bus.IMemRd !== 1'b0) begin errors++; $display("[TB] FAIL halt_rd[%0d]: got %b expected 0", i, bus.IMemRd); end
      checks++; if (bus.InstValid !== 1'b0) begin errors++; $display("[TB] FAIL halt_valid[%0d]: got %b expected 0", i, bus.InstValid); end
      nextCycle();
    end
    idleInputs();
    #1;
    checks++; if (bus.IMemAddr !== 16'h0000) begin errors++; $display("[TB] FAIL halt_pc_kept: got %h expected %h", bus.IMemAddr, 16'h0000); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL halt_err: got %b expected 0", bus.err); end
    doReset();
    checks++; if (bus.Halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_reset_halted: got %b expected 0", bus.Halted); end
    checks++; if (bus.IMemRd !== 1'b1 || bus.IMemAddr !== 16'h0000) begin errors++; $display("[TB] FAIL halt_restart: got rd=%b addr=%h expected rd=1 addr=0000", bus.IMemRd, bus.IMemAddr); end
  endtask

  task automatic test_odd_redirect();
    bus.Redirect    = 1'b1;
    bus.Redirect_PC = 16'h0033;
    nextCycle();
    idleInputs();
    #1;
    checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL odd_err: got %b expected 1", bus.err); end
    checks++; if (bus.IMemAddr !== 16'h0032) begin errors++; $display("[TB] FAIL odd_addr: got %h expected %h", bus.IMemAddr, 16'h0032); end
    fetchWord(16'h4000);
    checks++; if (bus.PCInc !== 16'h0034) begin errors++; $display("[TB] FAIL odd_pcinc: got %h expected %h", bus.PCInc, 16'h0034); end
    nextCycle();
    checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL odd_err_sticky: got %b expected 1", bus.err); end
    checks++; if (bus.IMemAddr !== 16'h0034) begin errors++; $display("[TB] FAIL odd_next_addr: got %h expected %h", bus.IMemAddr, 16'h0034); end
    doReset();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL odd_err_cleared: got %b expected 0", bus.err); end
  endtask

  task automatic test_done_violation();
    bus.IMemStall = 1'b1;
    bus.IMemDone  = 1'b1;
    bus.IMemData  = 16'hBEEF;
    nextCycle();
    idleInputs();
    #1;
    checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL viol_err: got %b expected 1", bus.err); end
    checks++; if (bus.IMemRd !== 1'b1) begin errors++; $display("[TB] FAIL viol_rd: got %b expected 1", bus.IMemRd); end
    checks++; if (bus.instruct !== 16'h0800) begin errors++; $display("[TB] FAIL viol_instruct: got %h expected %h", bus.instruct, 16'h0800); end
    doReset();
  endtask

  initial begin
    idleInputs();
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_stall();
    test_mem_stall();
    test_halt_wrap();
    test_odd_redirect();
    test_done_violation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the pipelined WISC core. It is the producer side of the IF/ID interface that the decode stage consumes: it owns the PC and issues reads to the multi-cycle instruction memory/cache. It presents each fetched instruction with its PC+2 and accepts redirects (taken branch or jump target) computed by decode.

## Interface
Parameters:
- none. Constants live in the shared package (see Structure).

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `Stall` in 1: hazard unit holds IF/ID; the presented instruction is not consumed.
- `Redirect` in 1: decode resolved a taken branch or jump this cycle.
- `Redirect_PC` in 16: target address (decode `Branch_PC`).
- `IMemData` in 16: instruction word; valid only when `IMemDone`=1.
- `IMemDone` in 1: one-cycle pulse, read data returned.
- `IMemStall` in 1: memory busy; a request in this cycle is not accepted.
- `IMemAddr` out 16: read address, equal to the PC.
- `IMemRd` out 1: read request.
- `instruct` out 16: instruction to IF/ID.
- `PCInc` out 16: PC+2 of `instruct`.
- `InstValid` out 1: `instruct` is a real, non-squashed instruction.
- `Halted` out 1: a HALT instruction was consumed; fetching has stopped.
- `err` out 1: sticky error flag.

## Operation
- State machine states: FETCH, WAIT, SQUASH, PRESENT, HALT.
- **FETCH** (`IMemRd`=1, `IMemAddr`=PC):
  - `Redirect`=1: PC ← `Redirect_PC` & 16'hFFFE, `IMemRd` forced 0, stay in FETCH.
  - Else `IMemStall`=1: stay in FETCH.
  - Else: request accepted → WAIT.
- **WAIT**:
  - `Redirect`=1: PC ← target. If `IMemDone` arrives in the same cycle, discard the data → FETCH; otherwise → SQUASH.
  - Else `IMemDone`=1: `instruct` ← `IMemData`, `PCInc` ← PC+2, PC ← PC+2 → PRESENT.
- **SQUASH**:
  - Wait for `IMemDone` and discard the data → FETCH.
  - A `Redirect` in this state updates the PC and stays in SQUASH.
- **PRESENT** (`InstValid`=1 unless `Redirect`=1):
  - `Redirect` has priority over `Stall`: the presented instruction is wrong-path. Squash it, set `instruct` ← 16'h0800 (NOP), PC ← target → FETCH.
  - Else `Stall`=1: hold all outputs and stay.
  - Else the instruction is consumed. If `instruct[15:11]`==5'b00000 (HALT) → HALT; otherwise → FETCH and `instruct` ← NOP.
- **HALT**:
  - `Halted`=1, `IMemRd`=0, `InstValid`=0.
  - `Redirect` is ignored; the only exit is `rst`.
- PC arithmetic is 16-bit modulo: 16'hFFFE+2 = 16'h0000, with no error.
- `err` is set and held until `rst` on any of:
  - `Redirect` with `Redirect_PC[0]`=1. The PC still loads the target with bit 0 cleared.
  - `IMemDone` in FETCH, PRESENT or HALT (a protocol violation). That data is ignored.

## Timing
- Reset values: PC=0, state=FETCH, `instruct`=16'h0800, `PCInc`=0, `InstValid`=0, `Halted`=0, `err`=0.
- `IMemAddr`, `IMemRd` and `InstValid` decode combinationally from state, PC and `Redirect`. All other outputs are registered.
- Minimum latency from request acceptance (cycle N) to presentation:
  - `IMemDone` at N+1 at the earliest.
  - `InstValid` at N+2.
- Best-case throughput is one instruction per 3 cycles.
- Consumption handshake: an instruction is consumed in a cycle with `InstValid`=1 and `Stall`=0. The consumer samples `instruct` and `PCInc` on that edge.
- `rst` asserted in any state, including mid-WAIT, returns to reset values on the next edge. A late `IMemDone` that arrives afterwards in FETCH sets `err`. The bench must not drive such a `IMemDone`.

## Structure
- Shared package `fetch_pkg`:
  - state encoding (3 bits);
  - `NOP_INSTR`=16'h0800;
  - `HALT_OPC`=5'b00000;
  - `PC_STEP`=16'd2.
- PC+2 uses the existing `rca_16b` adder (C_in=0, carry out ignored). No other sub-module.
- One registered state block and one combinational next-state/output block.

## Test plan
- Reset, then memory returns 16'h4A21 for address 0 with 1-cycle latency and `Stall`=0 → `IMemAddr`=0 at cycle 0, `InstValid`=1 at cycle 2 with `instruct`=16'h4A21 and `PCInc`=2, next request to address 2.
- `Stall` held for 3 cycles in PRESENT → `instruct`/`PCInc` unchanged and no new `IMemRd` until `Stall` drops.
- `Redirect` with `Redirect_PC`=16'h0100 while in WAIT, `IMemDone` two cycles later with data 16'hDEAD → data never presented; next request is to 16'h0100.
- `Redirect` and `Stall` together in PRESENT → `InstValid`=0 that cycle and the next fetch is at the redirect target.
- PC=16'hFFFE, fetch 16'h0000 → `PCInc`=0; once consumed, `Halted`=1 and `IMemRd` stays 0 for 10 cycles; `rst` restarts fetch at address 0.
- `Redirect_PC`=16'h0033 → `err`=1 held until `rst`; next fetch address is 16'h0032.
